// File: rtl/mag_peak_detect.sv
// rtl/mag_peak_detect.sv - frame-based peak search over the magnitude stream
// Optional noise-sum accumulator and Sum_Out port enabled by NOISE_SUM_EN.
module mag_peak_detect #(
   parameter int DW        = 29,
   parameter int FRAME_LEN = 1024,
   parameter int IDX_W     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             Nd,
   input  logic [DW-1:0]    Din,
   input  logic [DW-1:0]    Thresh,
   output logic             Busy,
   output logic             Det_Rdy,
   output logic [DW-1:0]    Peak_Val,
   output logic [IDX_W-1:0] Peak_Idx,
   output logic             Det_Hit
`ifdef NOISE_SUM_EN
   ,
   output logic [DW+IDX_W-1:0] Sum_Out
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] max_idx;
   logic [DW-1:0]    max_val;
   logic [DW-1:0]    thr;
   logic             start_acc;
   logic             take;

   assign start_acc = (state == IDLE) && Start;
   assign take      = (state == SEARCH) && Nd;
   assign Busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (Start) state_nx = SEARCH;
         SEARCH:  if (Nd && (cnt == LAST_IDX)) state_nx = REPORT;
         REPORT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         max_val  <= '0;
         max_idx  <= '0;
         thr      <= '0;
         Peak_Val <= '0;
         Peak_Idx <= '0;
         Det_Hit  <= 1'b0;
         Det_Rdy  <= 1'b0;
      end else begin
         Det_Rdy <= 1'b0;
         if (start_acc) begin
            cnt     <= '0;
            max_val <= '0;
            max_idx <= '0;
            thr     <= Thresh;
         end
         if (take) begin
            // Strict compare so ties keep the earliest index.
            if (Din > max_val) begin
               max_val <= Din;
               max_idx <= cnt;
            end
            if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
         end
         if (state == REPORT) begin
            Peak_Val <= max_val;
            Peak_Idx <= max_idx;
            Det_Hit  <= (max_val >= thr);
            Det_Rdy  <= 1'b1;
         end
      end
   end

`ifdef NOISE_SUM_EN
   logic [DW+IDX_W-1:0] sum_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_acc <= '0;
         Sum_Out <= '0;
      end else begin
         if (start_acc) sum_acc <= '0;
         else if (take) sum_acc <= sum_acc + (DW+IDX_W)'(Din);
         if (state == REPORT) Sum_Out <= sum_acc;
      end
   end
`endif

endmodule

// File: tb/tb_mag_peak_detect.sv
// tb/tb_mag_peak_detect.sv - directed self-checking bench for mag_peak_detect
// Sum_Out checks are included when NOISE_SUM_EN is defined.
module tb_mag_peak_detect;

   localparam int DW    = 29;
   localparam int FLEN  = 1024;
   localparam int IDX_W = 10;
   localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

   logic             clk = 1'b0;
   logic             rst;
   logic             Start;
   logic             Nd;
   logic [DW-1:0]    Din;
   logic [DW-1:0]    Thresh;
   logic             Busy;
   logic             Det_Rdy;
   logic [DW-1:0]    Peak_Val;
   logic [IDX_W-1:0] Peak_Idx;
   logic             Det_Hit;
`ifdef NOISE_SUM_EN
   logic [DW+IDX_W-1:0] sum_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_cnt  = 0;
   logic [DW-1:0] prev_peak = '0;

   mag_peak_detect #(.DW(DW), .FRAME_LEN(FLEN), .IDX_W(IDX_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .Start    (Start),
      .Nd       (Nd),
      .Din      (Din),
      .Thresh   (Thresh),
      .Busy     (Busy),
      .Det_Rdy  (Det_Rdy),
      .Peak_Val (Peak_Val),
      .Peak_Idx (Peak_Idx),
      .Det_Hit  (Det_Hit)
`ifdef NOISE_SUM_EN
      ,
      .Sum_Out  (sum_out)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (Det_Rdy) rdy_cnt++;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] din_of(input int mode, input int i);
      case (mode)
         0:       return DW'(i);
         1:       return DW'(7);
         2:       return (i == 100) ? ALL1 : DW'(5);
         default: return ALL1;
      endcase
   endfunction

   // Caller is #1 after a posedge; returns #1 after the Det_Rdy edge.
   task automatic run_frame(input string tag, input int mode, input int gap,
                            input logic [DW-1:0] thr, input bit restart_300,
                            input logic [DW-1:0] exp_val, input int exp_idx,
                            input bit exp_hit, input logic [63:0] exp_sum);
      Thresh = thr;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
      check_eq({tag, "_busy_start"}, 64'(Busy), 64'd1);
      for (int i = 0; i < FLEN; i++) begin
         if (i > 0) repeat (gap - 1) tick();
         Din = din_of(mode, i);
         Nd  = 1'b1;
         if (restart_300 && i == 300) begin
            Start  = 1'b1;
            Thresh = ALL1;
         end
         tick();
         Nd    = 1'b0;
         Start = 1'b0;
         if (i == 0) check_eq({tag, "_hold_prev"}, 64'(Peak_Val), 64'(prev_peak));
      end
      check_eq({tag, "_rdy_t1"}, 64'(Det_Rdy), 64'd0);
      check_eq({tag, "_busy_t1"}, 64'(Busy), 64'd1);
      // A sample offered during REPORT must be dropped.
      Nd  = 1'b1;
      Din = ALL1;
      tick();
      Nd  = 1'b0;
      check_eq({tag, "_rdy_t2"}, 64'(Det_Rdy), 64'd1);
      check_eq({tag, "_busy_t2"}, 64'(Busy), 64'd0);
      check_eq({tag, "_val"}, 64'(Peak_Val), 64'(exp_val));
      check_eq({tag, "_idx"}, 64'(Peak_Idx), 64'(exp_idx));
      check_eq({tag, "_hit"}, 64'(Det_Hit), 64'(exp_hit));
`ifdef NOISE_SUM_EN
      check_eq({tag, "_sum"}, 64'(sum_out), exp_sum);
`else
      if (exp_sum == 64'hFFFF_FFFF_FFFF_FFFF) $display("note: sum sentinel unused");
`endif
      prev_peak = exp_val;
   endtask

   int rdy_snap;

   initial begin
      rst = 1'b1; Start = 1'b0; Nd = 1'b0; Din = '0; Thresh = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst_busy", 64'(Busy), 64'd0);
      check_eq("rst_rdy",  64'(Det_Rdy), 64'd0);
      check_eq("rst_val",  64'(Peak_Val), 64'd0);
      check_eq("rst_idx",  64'(Peak_Idx), 64'd0);
      check_eq("rst_hit",  64'(Det_Hit), 64'd0);

      // Nd while IDLE must not be counted.
      Nd = 1'b1; Din = ALL1;
      repeat (2) tick();
      Nd = 1'b0;
      check_eq("idle_nd_busy", 64'(Busy), 64'd0);

      run_frame("ramp", 0, 1, DW'(500), 1'b0, DW'(1023), 1023, 1'b1, 64'd523776);
      tick();
      check_eq("ramp_rdy_pulse", 64'(Det_Rdy), 64'd0);
      check_eq("ramp_val_hold", 64'(Peak_Val), 64'd1023);

      run_frame("tie", 1, 1, DW'(8), 1'b0, DW'(7), 0, 1'b0, 64'd7168);
      // Start in the Det_Rdy cycle is accepted.
      run_frame("sparse", 2, 3, ALL1, 1'b0, ALL1, 100, 1'b1, 64'd536876026);
      tick();
      run_frame("restart", 0, 1, DW'(0), 1'b1, DW'(1023), 1023, 1'b1, 64'd523776);
      tick();

      Thresh = '0;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
      for (int i = 0; i < 500; i++) begin
         Din = DW'(i + 3000);
         Nd  = 1'b1;
         tick();
      end
      Nd = 1'b0;
      rdy_snap = rdy_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("abort_busy", 64'(Busy), 64'd0);
      check_eq("abort_val",  64'(Peak_Val), 64'd0);
      check_eq("abort_idx",  64'(Peak_Idx), 64'd0);
      check_eq("abort_hit",  64'(Det_Hit), 64'd0);
`ifdef NOISE_SUM_EN
      check_eq("abort_sum",  64'(sum_out), 64'd0);
`endif
      repeat (5) tick();
      check_eq("abort_no_rdy", 64'(rdy_cnt), 64'(rdy_snap));
      prev_peak = '0;
      run_frame("after_abort", 1, 1, DW'(7), 1'b0, DW'(7), 0, 1'b1, 64'd7168);
      tick();

`ifdef NOISE_SUM_EN
      run_frame("sum_max", 3, 1, ALL1, 1'b0, ALL1, 0, 1'b1, 64'h7F_FFFF_FC00);
      tick();
      check_eq("rdy_total", 64'(rdy_cnt), 64'd6);
`else
      check_eq("rdy_total", 64'(rdy_cnt), 64'd5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
